// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types and helpers for the perceptron trainer
package perceptron_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARG  = 3'd1,
    S_RES  = 3'd2,
    S_ERR  = 3'd3,
    S_FBK  = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } trainer_state_e;

  typedef enum logic {
    TRAIN = 1'b0,
    EVAL  = 1'b1
  } mode_e;

  function automatic int ERR_W(input int w);
    return 2 * w;
  endfunction

  // Operands are zero-extended, so the difference spans -(2^W-1)..2^W-1 for W up to 16.
  function automatic logic signed [31:0] calc_err(input logic [15:0] tgt, input logic [15:0] res);
    return $signed({16'b0, tgt}) - $signed({16'b0, res});
  endfunction

endpackage

// File: rtl/perceptron_trainer_sample_table.sv
// rtl/perceptron_trainer_sample_table.sv - sample storage, one write port, one async read port
module sample_table #(
  parameter int DEPTH = 4,
  parameter int DW    = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wadr,
  input  logic [DW-1:0] i_wdat,
  input  logic [AW-1:0] i_radr,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_in_range;

  // Only a non-power-of-two depth can be addressed past its last entry.
  generate
    if ((1 << AW) == DEPTH) begin : g_pow2
      assign w_in_range = 1'b1;
    end else begin : g_chk
      assign w_in_range = (32'(i_wadr) < DEPTH);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_we && w_in_range) begin
      r_mem[i_wadr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_radr];

endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - epoch sequencer that trains then evaluates one perceptron
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N      = 2,
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int EPOCHS = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ld_stb,
  output logic                       o_ld_rdy,
  input  logic [$clog2(DEPTH)-1:0]   i_ld_adr,
  input  logic [N*W-1:0]             i_ld_arg,
  input  logic [W-1:0]               i_ld_tgt,
  input  logic                       i_go,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(DEPTH+1)-1:0] o_miss,
  output logic                       o_en,
  output logic                       o_arg_stb,
  input  logic                       i_arg_rdy,
  output logic [N*W-1:0]             o_arg_dat,
  input  logic                       i_res_stb,
  output logic                       o_res_rdy,
  input  logic [W-1:0]               i_res_dat,
  output logic                       o_err_stb,
  input  logic                       i_err_rdy,
  output logic [ERR_W(W)-1:0]        o_err_dat,
  input  logic                       i_fbk_stb,
  output logic                       o_fbk_rdy,
  input  logic [N*ERR_W(W)-1:0]      i_fbk_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(EPOCHS + 1);
  localparam int RW = ERR_W(W);
  localparam int DW = N * W + W;

  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_ARG  = S_ARG;
  localparam logic [2:0] ST_RES  = S_RES;
  localparam logic [2:0] ST_ERR  = S_ERR;
  localparam logic [2:0] ST_FBK  = S_FBK;
  localparam logic [2:0] ST_NEXT = S_NEXT;
  localparam logic [2:0] ST_DONE = S_DONE;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [EW-1:0] r_epoch;
  mode_e         r_mode;
  logic [RW-1:0] r_err;
  logic [MW-1:0] r_miss;
  logic          r_en, r_busy, r_done, r_ld_rdy;
  logic          r_arg_stb, r_res_rdy, r_err_stb, r_fbk_rdy;
  logic [DW-1:0] w_rdat;
  logic [W-1:0]  w_tgt;
  logic [RW-1:0] w_err;
  logic          w_last_idx;
  logic          w_idle_nxt;
  logic          w_fbk_unused;

  sample_table #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_table (
    .i_clk  (i_clk),
    .i_we   (i_ld_stb && r_ld_rdy),
    .i_wadr (i_ld_adr),
    .i_wdat ({i_ld_arg, i_ld_tgt}),
    .i_radr (r_idx),
    .o_rdat (w_rdat)
  );

  assign w_tgt        = w_rdat[W-1:0];
  assign w_err        = RW'(calc_err(16'(w_tgt), 16'(i_res_dat)));
  assign w_last_idx   = (r_idx == AW'(DEPTH - 1));
  assign w_idle_nxt   = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
  assign w_fbk_unused = ^i_fbk_dat;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_go)      w_state_nxt = ST_ARG;
      ST_ARG:           if (i_arg_rdy) w_state_nxt = ST_RES;
      ST_RES:           if (i_res_stb) w_state_nxt = (r_mode == TRAIN) ? ST_ERR : ST_NEXT;
      ST_ERR:           if (i_err_rdy) w_state_nxt = ST_FBK;
      ST_FBK:           if (i_fbk_stb) w_state_nxt = ST_NEXT;
      ST_NEXT:          w_state_nxt = (!w_last_idx || r_mode == TRAIN) ? ST_ARG : ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so no input reaches an output directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_epoch   <= '0;
      r_mode    <= TRAIN;
      r_err     <= '0;
      r_miss    <= '0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ld_rdy  <= 1'b1;
      r_arg_stb <= 1'b0;
      r_res_rdy <= 1'b0;
      r_err_stb <= 1'b0;
      r_fbk_rdy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arg_stb <= (w_state_nxt == ST_ARG);
      r_res_rdy <= (w_state_nxt == ST_RES);
      r_err_stb <= (w_state_nxt == ST_ERR);
      r_fbk_rdy <= (w_state_nxt == ST_FBK);
      r_done    <= (w_state_nxt == ST_DONE);
      r_ld_rdy  <= w_idle_nxt;
      r_busy    <= !w_idle_nxt;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_go) begin
            r_idx   <= '0;
            r_epoch <= '0;
            r_mode  <= TRAIN;
            r_en    <= 1'b1;
            r_miss  <= '0;
          end
        end
        ST_RES: begin
          if (i_res_stb) begin
            r_err <= w_err;
            if (r_mode == EVAL && w_err != '0) begin
              r_miss <= r_miss + MW'(1);
            end
          end
        end
        ST_NEXT: begin
          if (!w_last_idx) begin
            r_idx <= r_idx + AW'(1);
          end else if (r_mode == TRAIN) begin
            r_idx <= '0;
            if (r_epoch < EW'(EPOCHS - 1)) begin
              r_epoch <= r_epoch + EW'(1);
            end else begin
              r_mode <= EVAL;
              r_en   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ld_rdy  = r_ld_rdy;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_miss    = r_miss;
  assign o_en      = r_en;
  assign o_arg_stb = r_arg_stb;
  assign o_arg_dat = w_rdat[DW-1:W];
  assign o_res_rdy = r_res_rdy;
  assign o_err_stb = r_err_stb;
  assign o_err_dat = r_err;
  assign o_fbk_rdy = r_fbk_rdy;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench with a stub perceptron and transaction model
module tb_perceptron_trainer;

  localparam int N      = 2;
  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int EPOCHS = 10;
  localparam int NTRAIN = DEPTH * EPOCHS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst = 1'b1;
  logic        i_ld_stb = 1'b0;
  logic [1:0]  i_ld_adr = '0;
  logic [15:0] i_ld_arg = '0;
  logic [7:0]  i_ld_tgt = '0;
  logic        i_go = 1'b0;
  logic        i_arg_rdy = 1'b0;
  logic        i_res_stb = 1'b0;
  logic [7:0]  i_res_dat = '0;
  logic        i_err_rdy = 1'b0;
  logic        i_fbk_stb = 1'b0;
  logic [31:0] i_fbk_dat = '0;
  logic        o_ld_rdy, o_busy, o_done, o_en;
  logic [2:0]  o_miss;
  logic        o_arg_stb, o_res_rdy, o_err_stb, o_fbk_rdy;
  logic [15:0] o_arg_dat, o_err_dat;

  perceptron_trainer #(.N(N), .W(W), .DEPTH(DEPTH), .EPOCHS(EPOCHS)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ld_stb(i_ld_stb), .o_ld_rdy(o_ld_rdy), .i_ld_adr(i_ld_adr),
    .i_ld_arg(i_ld_arg), .i_ld_tgt(i_ld_tgt),
    .i_go(i_go), .o_busy(o_busy), .o_done(o_done), .o_miss(o_miss), .o_en(o_en),
    .o_arg_stb(o_arg_stb), .i_arg_rdy(i_arg_rdy), .o_arg_dat(o_arg_dat),
    .i_res_stb(i_res_stb), .o_res_rdy(o_res_rdy), .i_res_dat(i_res_dat),
    .o_err_stb(o_err_stb), .i_err_rdy(i_err_rdy), .o_err_dat(o_err_dat),
    .i_fbk_stb(i_fbk_stb), .o_fbk_rdy(o_fbk_rdy), .i_fbk_dat(i_fbk_dat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a copy of the table plus the transaction stream it implies.
  logic [15:0] m_arg [DEPTH];
  logic [7:0]  m_tgt [DEPTH];
  logic [15:0] last_err [DEPTH];
  bit          mon_en = 0, bp = 0, echo = 0, hold_err = 0;
  bit          p_res = 0, p_fbk = 0, cur_train = 0;
  bit          pw_arg = 0, pw_err = 0;
  logic [15:0] pd_arg = '0, pd_err = '0;
  logic [7:0]  cur_res = '0;
  int          cur_idx = 0;
  int          n_arg, n_res, n_err, n_fbk, n_en0, exp_miss, busy_cyc;

  function automatic logic [7:0] stub_res(input int idx);
    logic [15:0] a;
    a = m_arg[idx];
    if (echo) return m_tgt[idx];
    return a[15:8] | a[7:0];
  endfunction

  always @(negedge clk) begin
    if (!i_rst && i_ld_stb && o_ld_rdy) begin
      m_arg[i_ld_adr] = i_ld_arg;
      m_tgt[i_ld_adr] = i_ld_tgt;
    end
    if (i_rst) begin
      p_res = 0; p_fbk = 0; pw_arg = 0; pw_err = 0;
      i_res_stb = 1'b0; i_fbk_stb = 1'b0;
    end else if (mon_en) begin
      if (pw_arg) begin
        chk("arg_hold_stb", o_arg_stb, 1);
        chk("arg_hold_dat", o_arg_dat, pd_arg);
      end
      if (pw_err) begin
        chk("err_hold_stb", o_err_stb, 1);
        chk("err_hold_dat", o_err_dat, pd_err);
      end
      i_arg_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_err_rdy = hold_err ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      i_res_stb = p_res && (i_res_stb || !bp || $urandom_range(0, 2) == 0);
      i_fbk_stb = p_fbk && (i_fbk_stb || !bp || $urandom_range(0, 2) == 0);
      i_fbk_dat = $urandom;
      if (o_arg_stb && i_arg_rdy) begin
        cur_idx   = n_arg % DEPTH;
        cur_train = (n_arg < NTRAIN);
        chk("arg_dat", o_arg_dat, m_arg[cur_idx]);
        chk("arg_en", o_en, cur_train);
        if (!o_en) n_en0++;
        cur_res   = stub_res(cur_idx);
        i_res_dat = cur_res;
        p_res     = 1;
        n_arg++;
      end
      if (o_res_rdy && i_res_stb) begin
        n_res++;
        p_res = 0;
        if (!cur_train && cur_res != m_tgt[cur_idx]) exp_miss++;
      end
      if (o_err_stb && i_err_rdy) begin
        chk("err_dat", $signed(o_err_dat), int'(m_tgt[cur_idx]) - int'(cur_res));
        last_err[cur_idx] = o_err_dat;
        n_err++;
        p_fbk = 1;
      end
      if (o_fbk_rdy && i_fbk_stb) begin
        n_fbk++;
        p_fbk = 0;
      end
      pw_arg = o_arg_stb && !i_arg_rdy;
      pd_arg = o_arg_dat;
      pw_err = o_err_stb && !i_err_rdy;
      pd_err = o_err_dat;
      if (o_busy) busy_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int adr, input logic [15:0] arg, input logic [7:0] tgt);
    tick();
    i_ld_stb = 1'b1; i_ld_adr = 2'(adr); i_ld_arg = arg; i_ld_tgt = tgt;
    tick();
    i_ld_stb = 1'b0;
  endtask

  task automatic start_run(input bit with_ld, input int adr, input logic [15:0] arg, input logic [7:0] tgt);
    n_arg = 0; n_res = 0; n_err = 0; n_fbk = 0; n_en0 = 0; exp_miss = 0; busy_cyc = 0;
    p_res = 0; p_fbk = 0; pw_arg = 0; pw_err = 0;
    mon_en = 1;
    tick();
    i_go = 1'b1;
    if (with_ld) begin
      i_ld_stb = 1'b1; i_ld_adr = 2'(adr); i_ld_arg = arg; i_ld_tgt = tgt;
    end
    tick();
    i_go = 1'b0;
    i_ld_stb = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 4000 && !o_done; c++) @(negedge clk);
    chk("done_reached", o_done, 1);
  endtask

  task automatic finish_run(input int lit_miss, input int exp_busy);
    chk("miss_model", o_miss, exp_miss);
    chk("miss_literal", o_miss, lit_miss);
    if (exp_busy > 0) chk("busy_cycles", busy_cyc, exp_busy);
    chk("busy_low_at_done", o_busy, 0);
    chk("arg_handshakes", n_arg, 44);
    chk("res_handshakes", n_res, 44);
    chk("err_handshakes", n_err, 40);
    chk("fbk_handshakes", n_fbk, 40);
    chk("eval_args_en0", n_en0, 4);
    mon_en = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_arg_stb"}, o_arg_stb, 0);
    chk({tag, "_res_rdy"}, o_res_rdy, 0);
    chk({tag, "_err_stb"}, o_err_stb, 0);
    chk({tag, "_fbk_rdy"}, o_fbk_rdy, 0);
    chk({tag, "_en"}, o_en, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_miss"}, o_miss, 0);
    chk({tag, "_ld_rdy"}, o_ld_rdy, 1);
  endtask

  initial begin
    repeat (3) tick();
    i_rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");

    // AND table with a stub that already knows the answers
    load(0, 16'h0000, 8'h00);
    load(1, 16'h00ff, 8'h00);
    load(2, 16'hff00, 8'h00);
    load(3, 16'hffff, 8'hff);
    echo = 1;
    start_run(0, 0, '0, '0);
    wait_done();
    finish_run(0, 212);
    echo = 0;

    // OR stub on AND targets, with go and a load attempted mid-run
    start_run(0, 0, '0, '0);
    repeat (30) tick();
    i_go = 1'b1; i_ld_stb = 1'b1; i_ld_adr = 2'd0; i_ld_arg = 16'h1234; i_ld_tgt = 8'h55;
    @(negedge clk);
    chk("ld_rdy_while_busy", o_ld_rdy, 0);
    tick();
    i_go = 1'b0; i_ld_stb = 1'b0;
    wait_done();
    finish_run(2, 212);
    chk("err_res_ff_tgt_00", last_err[1], 16'hff01);

    // same run under backpressure
    bp = 1;
    start_run(0, 0, '0, '0);
    wait_done();
    finish_run(2, 0);
    bp = 0;

    // XOR targets cannot match the OR stub on the last sample
    load(1, 16'h00ff, 8'hff);
    load(2, 16'hff00, 8'hff);
    load(3, 16'hffff, 8'h00);
    start_run(0, 0, '0, '0);
    wait_done();
    finish_run(1, 212);

    // XNOR targets; entry 0 rewritten in the same cycle as go, then reset while err is held
    load(1, 16'h00ff, 8'h00);
    load(2, 16'hff00, 8'h00);
    load(3, 16'hffff, 8'hff);
    hold_err = 1;
    start_run(1, 0, 16'h0000, 8'hff);
    for (int c = 0; c < 50 && !o_err_stb; c++) @(negedge clk);
    chk("err_stb_seen", o_err_stb, 1);
    chk("err_res_00_tgt_ff", o_err_dat, 16'h00ff);
    repeat (3) @(negedge clk);
    mon_en = 0;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    hold_err = 0;
    @(negedge clk);
    reset_checks("midrst");

    start_run(0, 0, '0, '0);
    wait_done();
    finish_run(3, 212);
    chk("err_res_00_tgt_ff_rerun", last_err[0], 16'h00ff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
